vdma_wr_stream_to_axi4: RTL and testbench



---
 rtl/vdma_pkg.sv | 21 ++
 rtl/vdma_wr_stream_to_axi4.sv | 160 ++++++++++++++++
 tb/tb_vdma_wr_stream_to_axi4.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vdma_pkg.sv
// rtl/vdma_pkg.sv - shared states, response codes and burst sizing for the video write DMA
package vdma_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_AW       = 2'd1,
    ST_W        = 2'd2,
    ST_B        = 2'd3
  } wr_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // AXI awlen for the next burst; callers guarantee remaining >= 1.
  function automatic logic [7:0] burst_len(input logic [31:0] remaining,
                                           input logic [31:0] burst_max);
    logic [31:0] beats;
    beats = (remaining < burst_max) ? remaining : burst_max;
    return 8'(beats - 32'd1);
  endfunction

endpackage

// File: rtl/vdma_wr_stream_to_axi4.sv
// rtl/vdma_wr_stream_to_axi4.sv - frame stream to serialised AXI4 INCR write bursts
module vdma_wr_stream_to_axi4
  import vdma_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256,
  parameter int BURST_LEN  = 64,
  parameter int ADDR_STEP  = 8,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_beats,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic                  axi_wvalid,
  output logic                  axi_wlast,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic                  frame_done,
  output logic                  sof_err,
  output logic                  cfg_err,
  output logic                  resp_err
);

  wr_state_e             state_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic                  awvalid_q;
  logic                  bready_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt_q;
  logic                  first_beat_q;
  logic                  frame_done_q;
  logic                  sof_err_q;
  logic                  cfg_err_q;
  logic                  resp_err_q;

  logic                  wr_fire;
  logic [31:0]           burst_beats;
  logic [LEN_WIDTH-1:0]  remaining_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awvalid = awvalid_q;
  assign axi_bready  = bready_q;
  assign frame_done  = frame_done_q;
  assign sof_err     = sof_err_q;
  assign cfg_err     = cfg_err_q;
  assign resp_err    = resp_err_q;
  assign axi_wdata   = s_data;

  // W channel is a straight wire between stream and AXI; no skid buffer.
  always_comb begin
    s_ready    = 1'b0;
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
    unique case (state_q)
      ST_WAIT_SOF: s_ready = s_valid && (!s_sof || (cfg_frame_beats == '0));
      ST_W: begin
        s_ready    = axi_wready;
        axi_wvalid = s_valid;
        axi_wlast  = (beat_cnt_q == len_q);
      end
      default: ;
    endcase
  end

  assign wr_fire     = axi_wvalid && axi_wready;
  assign burst_beats = 32'(len_q) + 32'd1;
  assign remaining_d = remaining_q - LEN_WIDTH'(burst_beats);
  assign addr_d      = awaddr_q + ADDR_WIDTH'(burst_beats * 32'(ADDR_STEP));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= ST_WAIT_SOF;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      awvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      remaining_q  <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      first_beat_q <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      unique case (state_q)
        ST_WAIT_SOF: begin
          if (s_valid && s_sof) begin
            if (cfg_frame_beats == '0) begin
              cfg_err_q <= 1'b1;
            end else begin
              awaddr_q     <= cfg_base_addr;
              remaining_q  <= cfg_frame_beats;
              awlen_q      <= burst_len(32'(cfg_frame_beats), 32'(BURST_LEN));
              awvalid_q    <= 1'b1;
              first_beat_q <= 1'b1;
              state_q      <= ST_AW;
            end
          end
        end
        ST_AW: begin
          if (axi_awready) begin
            awvalid_q  <= 1'b0;
            len_q      <= awlen_q;
            beat_cnt_q <= '0;
            state_q    <= ST_W;
          end
        end
        ST_W: begin
          if (wr_fire) begin
            beat_cnt_q   <= beat_cnt_q + 8'd1;
            first_beat_q <= 1'b0;
            if (s_sof && !first_beat_q) sof_err_q <= 1'b1;
            if (beat_cnt_q == len_q) begin
              bready_q <= 1'b1;
              state_q  <= ST_B;
            end
          end
        end
        ST_B: begin
          if (axi_bvalid) begin
            bready_q    <= 1'b0;
            remaining_q <= remaining_d;
            awaddr_q    <= addr_d;
            if (axi_bresp != AXI_RESP_OKAY) resp_err_q <= 1'b1;
            if (remaining_d == '0) begin
              frame_done_q <= 1'b1;
              state_q      <= ST_WAIT_SOF;
            end else begin
              awlen_q   <= burst_len(32'(remaining_d), 32'(BURST_LEN));
              awvalid_q <= 1'b1;
              state_q   <= ST_AW;
            end
          end
        end
        default: state_q <= ST_WAIT_SOF;
      endcase
    end
  end

endmodule

// File: tb/tb_vdma_wr_stream_to_axi4.sv
// tb/tb_vdma_wr_stream_to_axi4.sv - scoreboard bench for the video write DMA
`timescale 1ns/1ps
module tb_vdma_wr_stream_to_axi4;

  localparam int AW    = 27;
  localparam int DW    = 256;
  localparam int LW    = 24;
  localparam int BURST = 64;
  localparam int STEP  = 8;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [LW-1:0] cfg_frame_beats = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_sof = 1'b0;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic          axi_awvalid;
  logic          axi_awready = 1'b1;
  logic [DW-1:0] axi_wdata;
  logic          axi_wvalid;
  logic          axi_wlast;
  logic          axi_wready = 1'b1;
  logic [1:0]    axi_bresp = 2'b00;
  logic          axi_bvalid = 1'b0;
  logic          axi_bready;
  logic          frame_done;
  logic          sof_err;
  logic          cfg_err;
  logic          resp_err;

  always #5 clock = ~clock;

  vdma_wr_stream_to_axi4 dut (
    .clock(clock), .rst(rst),
    .cfg_base_addr(cfg_base_addr), .cfg_frame_beats(cfg_frame_beats),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wlast(axi_wlast),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .frame_done(frame_done), .sof_err(sof_err), .cfg_err(cfg_err), .resp_err(resp_err)
  );

  typedef struct { logic [DW-1:0] data; logic last; } wbeat_t;
  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
  typedef struct {
    logic [AW-1:0] base;
    int            beats;
    int            bursts;
    logic [7:0]    last_len;
    logic [AW-1:0] addr2;
  } vec_t;

  wbeat_t        exp_w[$];
  aw_t           exp_aw[$];
  logic [AW-1:0] aw_hist[$];
  wbeat_t        ew;
  aw_t           ea;

  int tests = 0;
  int fails = 0;
  int aw_cnt = 0, w_cnt = 0, wlast_cnt = 0, b_cnt = 0;
  int done_cnt = 0, cfg_err_cnt = 0, sof_err_cnt = 0;
  logic [7:0] last_awlen = '0;
  logic wready_toggle = 1'b0;
  int   err_b_num = 0;
  int   b_issued = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor and scoreboard: sample handshakes half a cycle away from the active edge.
  always @(negedge clock) begin
    if (!rst) begin
      if (axi_awvalid && axi_awready) begin
        aw_cnt++;
        last_awlen = axi_awlen;
        aw_hist.push_back(axi_awaddr);
        if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          ea = exp_aw.pop_front();
          check("awaddr", 64'(axi_awaddr), 64'(ea.addr));
          check("awlen", 64'(axi_awlen), 64'(ea.len));
        end
      end
      if (axi_wvalid && axi_wready) begin
        w_cnt++;
        if (axi_wlast) wlast_cnt++;
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else begin
          ew = exp_w.pop_front();
          tests++;
          if (axi_wdata !== ew.data) begin
            fails++;
            $display("FAIL wdata beat %0d: got 0x%0h expected 0x%0h", w_cnt, axi_wdata[63:0], ew.data[63:0]);
          end
          check("wlast", 64'(axi_wlast), 64'(ew.last));
        end
      end
      if (axi_bvalid && axi_bready) b_cnt++;
      if (frame_done) done_cnt++;
      if (cfg_err) cfg_err_cnt++;
      if (sof_err) sof_err_cnt++;
    end
  end

  // AXI slave: awready tied high, optional wready toggling, one B per observed wlast.
  always @(posedge clock) begin
    #1;
    if (rst) begin
      axi_bvalid = 1'b0;
      axi_wready = 1'b1;
      b_issued   = wlast_cnt;
    end else begin
      axi_wready = wready_toggle ? ~axi_wready : 1'b1;
      if (axi_bvalid && (b_cnt == b_issued)) axi_bvalid = 1'b0;
      if (!axi_bvalid && (wlast_cnt > b_issued)) begin
        b_issued++;
        axi_bvalid = 1'b1;
        axi_bresp  = (b_issued == err_b_num) ? 2'b10 : 2'b00;
      end
    end
  end

  task automatic push_aws(input logic [AW-1:0] base, input int beats);
    logic [AW-1:0] a;
    int rem;
    int n;
    a   = base;
    rem = beats;
    while (rem > 0) begin
      n = (rem < BURST) ? rem : BURST;
      exp_aw.push_back('{addr: a, len: 8'(n - 1)});
      a   = a + AW'(n * STEP);
      rem = rem - n;
    end
  endtask

  task automatic drive_beats(input int n, input int frame_beats, input int sof_idx, input bit gaps);
    logic [DW-1:0] d;
    int wait_cnt;
    for (int i = 0; i < n; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      s_valid = 1'b1;
      s_sof   = (i == 0) || (i == sof_idx);
      s_data  = d;
      exp_w.push_back('{data: d, last: ((i % BURST) == BURST - 1) || (i == frame_beats - 1)});
      wait_cnt = 0;
      do begin
        @(negedge clock);
        wait_cnt++;
      end while (!s_ready && wait_cnt < 1000);
      check("stream_handshake", 64'(s_ready), 1);
      @(posedge clock); #1;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      if (i == 0) begin
        cfg_base_addr   = 27'h1234;
        cfg_frame_beats = 24'd5;
      end
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check("frame_done_count", 64'(done_cnt), 64'(target));
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input int beats, input int sof_idx, input bit gaps);
    int d0;
    d0 = done_cnt;
    aw_hist.delete();
    cfg_base_addr   = base;
    cfg_frame_beats = LW'(beats);
    push_aws(base, beats);
    drive_beats(beats, beats, sof_idx, gaps);
    wait_done(d0 + 1);
    repeat (3) @(posedge clock);
    #1;
    check("exp_w_drained", 64'(exp_w.size()), 0);
    check("exp_aw_drained", 64'(exp_aw.size()), 0);
  endtask

  vec_t vecs[6];

  initial begin : main
    int aw0, w0, wl0, se0, ce0, d0;

    vecs[0] = '{base: 27'h100,     beats: 128, bursts: 2, last_len: 8'd63, addr2: 27'h300};
    vecs[1] = '{base: 27'h100,     beats: 70,  bursts: 2, last_len: 8'd5,  addr2: 27'h300};
    vecs[2] = '{base: 27'h2000,    beats: 1,   bursts: 1, last_len: 8'd0,  addr2: 27'h0};
    vecs[3] = '{base: 27'h7FFFF00, beats: 96,  bursts: 2, last_len: 8'd31, addr2: 27'h100};
    vecs[4] = '{base: 27'h40,      beats: 64,  bursts: 1, last_len: 8'd63, addr2: 27'h0};
    vecs[5] = '{base: 27'h0,       beats: 200, bursts: 4, last_len: 8'd7,  addr2: 27'h200};

    repeat (3) @(negedge clock);
    check("reset_outputs",
          {20'd0, axi_awvalid, axi_wvalid, axi_wlast, s_ready, axi_bready,
           frame_done, sof_err, cfg_err, resp_err, axi_awaddr, axi_awlen}, 64'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) begin
      aw0 = aw_cnt; w0 = w_cnt; wl0 = wlast_cnt; se0 = sof_err_cnt;
      run_frame(vecs[i].base, vecs[i].beats, -1, 1'b0);
      check($sformatf("v%0d_bursts", i), 64'(aw_cnt - aw0), 64'(vecs[i].bursts));
      check($sformatf("v%0d_last_awlen", i), 64'(last_awlen), 64'(vecs[i].last_len));
      check($sformatf("v%0d_w_beats", i), 64'(w_cnt - w0), 64'(vecs[i].beats));
      check($sformatf("v%0d_wlast_count", i), 64'(wlast_cnt - wl0), 64'(vecs[i].bursts));
      check($sformatf("v%0d_no_sof_err", i), 64'(sof_err_cnt - se0), 0);
      if (vecs[i].bursts > 1 && aw_hist.size() > 1)
        check($sformatf("v%0d_addr2", i), 64'(aw_hist[1]), 64'(vecs[i].addr2));
    end

    // Non-SOF beats while idle are swallowed without any AXI activity.
    aw0 = aw_cnt; w0 = w_cnt;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_sof = 1'b0; s_data = DW'(i + 1);
      @(negedge clock);
      check("presof_drop_ready", 64'(s_ready), 1);
      @(posedge clock); #1;
    end
    s_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("presof_no_aw", 64'(aw_cnt - aw0), 0);
    check("presof_no_w", 64'(w_cnt - w0), 0);
    run_frame(27'h500, 64, -1, 1'b0);
    check("presof_frame_aw", 64'(aw_cnt - aw0), 1);

    // Backpressure and stream gaps.
    wready_toggle = 1'b1;
    w0 = w_cnt; wl0 = wlast_cnt;
    run_frame(27'h4000, 64, -1, 1'b1);
    check("toggle_w_beats", 64'(w_cnt - w0), 64);
    check("toggle_wlast", 64'(wlast_cnt - wl0), 1);
    wready_toggle = 1'b0;

    // Stray SOF mid-frame is written and flagged once.
    se0 = sof_err_cnt; w0 = w_cnt;
    run_frame(27'hA00, 100, 70, 1'b0);
    check("midsof_err_pulse", 64'(sof_err_cnt - se0), 1);
    check("midsof_w_beats", 64'(w_cnt - w0), 100);

    // Zero-length frame configuration.
    aw0 = aw_cnt; ce0 = cfg_err_cnt;
    cfg_frame_beats = '0; cfg_base_addr = 27'h600;
    s_valid = 1'b1; s_sof = 1'b1;
    @(negedge clock);
    check("cfg0_sof_consumed", 64'(s_ready), 1);
    @(posedge clock); #1;
    s_valid = 1'b0; s_sof = 1'b0;
    @(negedge clock);
    check("cfg0_err_high", 64'(cfg_err), 1);
    @(negedge clock);
    check("cfg0_err_pulse_end", 64'(cfg_err), 0);
    repeat (5) @(negedge clock);
    check("cfg0_err_count", 64'(cfg_err_cnt - ce0), 1);
    check("cfg0_no_aw", 64'(aw_cnt - aw0), 0);
    check("cfg0_awvalid_low", 64'(axi_awvalid), 0);
    @(posedge clock); #1;

    // Error response on the first B of a frame; sticky until reset.
    check("resp_err_clear_before", 64'(resp_err), 0);
    err_b_num = b_issued + 1;
    d0 = done_cnt;
    run_frame(27'h800, 128, -1, 1'b0);
    check("resp_err_set", 64'(resp_err), 1);
    check("resp_err_frame_done", 64'(done_cnt - d0), 1);
    run_frame(27'h900, 64, -1, 1'b0);
    check("resp_err_sticky", 64'(resp_err), 1);

    // Reset in the middle of a burst, then restart at a new base.
    cfg_base_addr = 27'h1000; cfg_frame_beats = 24'd128;
    push_aws(27'h1000, 128);
    drive_beats(10, 128, -1, 1'b0);
    rst = 1'b1;
    exp_aw.delete();
    exp_w.delete();
    @(negedge clock);
    check("midrst_outputs",
          {20'd0, axi_awvalid, axi_wvalid, axi_wlast, s_ready, axi_bready,
           frame_done, sof_err, cfg_err, resp_err, axi_awaddr, axi_awlen}, 64'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(posedge clock); #1;
    aw0 = aw_cnt;
    run_frame(27'h3000, 64, -1, 1'b0);
    check("midrst_restart_aw", 64'(aw_cnt - aw0), 1);
    if (aw_hist.size() > 0) check("midrst_restart_addr", 64'(aw_hist[0]), 64'h3000);
    else check("midrst_restart_addr_seen", 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
